// File: rtl/draw_puck_pkg.sv
// Shared constants and the timing-bus payload type for the puck overlay stage.
package draw_puck_pkg;

    localparam int unsigned CNT_W    = 12;
    localparam int unsigned RGB_W    = 12;
    localparam int unsigned DIFF_W   = CNT_W + 1;
    localparam int unsigned SQ_W     = 27;
    localparam int unsigned H_ACTIVE = 1024;
    localparam int unsigned V_ACTIVE = 768;

    localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;

    // Timing signals travelling alongside the pixel stream
    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic             hsync;
        logic             hblnk;
        logic [CNT_W-1:0] vcount;
        logic             vsync;
        logic             vblnk;
    } vga_timing_t;

    // Signed distance between two unsigned screen coordinates, never wrapping
    function automatic logic signed [DIFF_W-1:0] coord_diff(input logic [CNT_W-1:0] a,
                                                            input logic [CNT_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

endpackage

// File: rtl/vga_bus_delay.sv
// Fixed-depth delay line for the VGA timing bus.
module vga_bus_delay
    import draw_puck_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  vga_timing_t bus_in,
    output vga_timing_t bus_out
);

    vga_timing_t stage_q [DEPTH];

    // Shift the timing bus one stage per pixel clock
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= bus_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign bus_out = stage_q[DEPTH-1];

endmodule

// File: rtl/draw_puck.sv
// Overlay stage: paints a filled circular puck over the incoming rgb stream.
// Centre position is latched once per frame at the rising edge of vertical blank.
module draw_puck
    import draw_puck_pkg::*;
#(
    parameter int unsigned      RADIUS   = 16,
    parameter logic [RGB_W-1:0] PUCK_RGB = 12'h000,
    parameter logic [CNT_W-1:0] INIT_X   = CNT_W'(H_ACTIVE / 2),
    parameter logic [CNT_W-1:0] INIT_Y   = CNT_W'(V_ACTIVE / 2)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] hcount_in,
    input  logic             hsync_in,
    input  logic             hblnk_in,
    input  logic [CNT_W-1:0] vcount_in,
    input  logic             vsync_in,
    input  logic             vblnk_in,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic [CNT_W-1:0] xpos,
    input  logic [CNT_W-1:0] ypos,
    output logic [CNT_W-1:0] hcount_out,
    output logic             hsync_out,
    output logic             hblnk_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             vsync_out,
    output logic             vblnk_out,
    output logic [RGB_W-1:0] rgb_out
);

    localparam logic [SQ_W-1:0] R_SQ = SQ_W'(RADIUS * RADIUS);

    logic             vblnk_d;
    logic             vblnk_rise_c;
    logic [CNT_W-1:0] x_lat;
    logic [CNT_W-1:0] y_lat;

    logic signed [DIFF_W-1:0] dx_s1;
    logic signed [DIFF_W-1:0] dy_s1;
    logic [RGB_W-1:0]         rgb_s1;
    logic                     blank_s1;

    logic signed [2*DIFF_W-1:0] dx_sq_c;
    logic signed [2*DIFF_W-1:0] dy_sq_c;
    logic [SQ_W-1:0]            sq_c;
    logic                       inside_c;

    vga_timing_t bus_in_c;
    vga_timing_t bus_out_c;

    assign vblnk_rise_c = vblnk_in & ~vblnk_d;

    // Latch the requested centre only when vertical blank begins
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_d <= 1'b0;
            x_lat   <= INIT_X;
            y_lat   <= INIT_Y;
        end else begin
            vblnk_d <= vblnk_in;
            if (vblnk_rise_c) begin
                x_lat <= xpos;
                y_lat <= ypos;
            end
        end
    end

    // Stage 1: signed offsets from the centre plus the pixel colour and blank flag
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            dx_s1    <= '0;
            dy_s1    <= '0;
            rgb_s1   <= '0;
            blank_s1 <= 1'b0;
        end else begin
            dx_s1    <= coord_diff(hcount_in, x_lat);
            dy_s1    <= coord_diff(vcount_in, y_lat);
            rgb_s1   <= rgb_in;
            blank_s1 <= hblnk_in | vblnk_in;
        end
    end

    // Squared distance; each square is non-negative so the sum fits unsigned
    assign dx_sq_c  = dx_s1 * dx_s1;
    assign dy_sq_c  = dy_s1 * dy_s1;
    assign sq_c     = SQ_W'($unsigned(dx_sq_c)) + SQ_W'($unsigned(dy_sq_c));
    assign inside_c = (sq_c <= R_SQ);

    // Stage 2: composite the output pixel
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out <= '0;
        end else if (blank_s1) begin
            rgb_out <= RGB_BLACK;
        end else if (inside_c) begin
            rgb_out <= PUCK_RGB;
        end else begin
            rgb_out <= rgb_s1;
        end
    end

    assign bus_in_c = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                        vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};

    vga_bus_delay #(
        .DEPTH (2)
    ) u_bus_delay (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .bus_in  (bus_in_c),
        .bus_out (bus_out_c)
    );

    assign hcount_out = bus_out_c.hcount;
    assign hsync_out  = bus_out_c.hsync;
    assign hblnk_out  = bus_out_c.hblnk;
    assign vcount_out = bus_out_c.vcount;
    assign vsync_out  = bus_out_c.vsync;
    assign vblnk_out  = bus_out_c.vblnk;

endmodule

// File: tb/tb_draw_puck.sv
// Self-checking bench for draw_puck: behavioural model with a 2-deep expectation queue.
module tb_draw_puck;

    localparam int          R      = 16;
    localparam logic [11:0] PUCK   = 12'h000;
    localparam int          INIT_X = 512;
    localparam int          INIT_Y = 384;
    localparam logic [11:0] GRN    = 12'h0F0;

    logic        clk_in;
    logic        rst_n;
    logic [11:0] hcount_in, vcount_in, rgb_in, xpos, ypos;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;

    int          total;
    int          bad;
    int          mx, my;
    logic        m_vb_prev;
    logic [39:0] q[$];

    draw_puck dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .hcount_in  (hcount_in),
        .hsync_in   (hsync_in),
        .hblnk_in   (hblnk_in),
        .vcount_in  (vcount_in),
        .vsync_in   (vsync_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .hcount_out (hcount_out),
        .hsync_out  (hsync_out),
        .hblnk_out  (hblnk_out),
        .vcount_out (vcount_out),
        .vsync_out  (vsync_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [39:0] all_outs();
        return {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out};
    endfunction

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference state after reset: centre at INIT, stage 1 holding zeros
    task automatic reset_model();
        q.delete();
        q.push_back(40'h0);
        mx = INIT_X;
        my = INIT_Y;
        m_vb_prev = 1'b0;
    endtask

    // One pixel clock: model the expected output, advance, compare what is due
    task automatic step(input logic [11:0] h, input logic [11:0] v, input logic hs,
                        input logic hb, input logic vs, input logic vb, input logic [11:0] rgb);
        int          ddx, ddy;
        logic [11:0] exp_rgb;
        logic [39:0] exp;
        hcount_in = h; vcount_in = v; hsync_in = hs; hblnk_in = hb;
        vsync_in = vs; vblnk_in = vb; rgb_in = rgb;
        ddx = int'(h) - mx;
        ddy = int'(v) - my;
        if (hb || vb)                      exp_rgb = 12'h000;
        else if (ddx*ddx + ddy*ddy <= R*R) exp_rgb = PUCK;
        else                               exp_rgb = rgb;
        q.push_back({h, v, hs, hb, vs, vb, exp_rgb});
        if (vb && !m_vb_prev) begin
            mx = int'(xpos);
            my = int'(ypos);
        end
        m_vb_prev = vb;
        @(posedge clk_in);
        #1;
        if (q.size() >= 2) begin
            exp = q.pop_front();
            check("timing", {12'h0, all_outs() >> 12}, {12'h0, exp[39:12]});
            check("rgb", {28'h0, rgb_out}, {28'h0, exp[11:0]});
        end
    endtask

    // Drive one pixel, flush it with a blank filler, then check a literal result
    task automatic pixel(input logic [11:0] h, input logic [11:0] v, input logic hb,
                         input logic vb, input logic [11:0] rgb, input logic [11:0] exp_lit,
                         input string tag);
        step(h, v, 1'b0, hb, 1'b0, vb, rgb);
        step(12'd0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        check(tag, {28'h0, rgb_out}, {28'h0, exp_lit});
    endtask

    // Vertical blank pulse: one rising edge of vblnk_in
    task automatic vpulse();
        step(12'd0, 12'd790, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        step(12'd0, 12'd800, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
        step(12'd1, 12'd800, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
        step(12'd0, 12'd0,   1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        {hcount_in, vcount_in, rgb_in} = '0;
        {hsync_in, hblnk_in, vsync_in, vblnk_in} = '0;
        xpos = 12'd512;
        ypos = 12'd384;

        // Reset held with random inputs: every output stays zero
        for (int i = 0; i < 5; i++) begin
            hcount_in = 12'($urandom); vcount_in = 12'($urandom); rgb_in = 12'($urandom);
            {hsync_in, hblnk_in, vsync_in, vblnk_in} = 4'($urandom);
            xpos = 12'($urandom); ypos = 12'($urandom);
            @(posedge clk_in);
            #1;
            check("reset_hold", all_outs(), 40'h0);
        end
        rst_n = 1'b1;
        reset_model();
        xpos = 12'd512;
        ypos = 12'd384;

        // Centre hits against the INIT position
        pixel(12'd512, 12'd384, 1'b0, 1'b0, GRN, PUCK, "centre");
        pixel(12'd528, 12'd384, 1'b0, 1'b0, GRN, PUCK, "radius_edge");
        pixel(12'd529, 12'd384, 1'b0, 1'b0, GRN, GRN,  "radius_out");
        pixel(12'd524, 12'd396, 1'b0, 1'b0, GRN, GRN,  "diag_out");

        // Mid-frame position change only applies after the next vblank rise
        xpos = 12'd100;
        pixel(12'd512, 12'd384, 1'b0, 1'b0, GRN, PUCK, "latch_old");
        pixel(12'd100, 12'd384, 1'b0, 1'b0, GRN, GRN,  "latch_not_yet");
        vpulse();
        pixel(12'd100, 12'd384, 1'b0, 1'b0, GRN, PUCK, "latch_new");
        pixel(12'd512, 12'd384, 1'b0, 1'b0, GRN, GRN,  "latch_old_gone");

        // Corner puck clips without wrapping to the far edge
        xpos = 12'd0;
        ypos = 12'd0;
        vpulse();
        for (int h = 0; h <= 16; h++) pixel(12'(h), 12'd0, 1'b0, 1'b0, GRN, PUCK, "clip_in");
        pixel(12'd17, 12'd0, 1'b0, 1'b0, GRN, GRN, "clip_edge");
        for (int h = 4080; h <= 4095; h++) pixel(12'(h), 12'd0, 1'b0, 1'b0, GRN, GRN, "clip_wrap");
        pixel(12'd0, 12'd4095, 1'b0, 1'b0, GRN, GRN, "clip_wrap_v");

        // Blanking forces black regardless of the circle
        pixel(12'd5, 12'd0, 1'b1, 1'b0, GRN, 12'h000, "hblank_inside");
        pixel(12'd100, 12'd50, 1'b0, 1'b1, GRN, 12'h000, "vblank_outside");

        // Scan full-width lines through a puck at (600,384)
        xpos = 12'd600;
        ypos = 12'd384;
        vpulse();
        for (int v = 376; v <= 392; v++) begin
            for (int h = 0; h < 1344; h++) begin
                step(12'(h), 12'(v), (h >= 1048 && h < 1184), (h >= 1024), 1'b0, 1'b0,
                     12'($urandom));
            end
        end

        // Random traffic with frequent re-latching anywhere in the 12-bit range
        begin
            logic vb_r;
            int   hh, vv;
            vb_r = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 99) < 4) vb_r = ~vb_r;
                xpos = 12'($urandom);
                ypos = 12'($urandom);
                hh = mx + $urandom_range(0, 48) - 24;
                vv = my + $urandom_range(0, 48) - 24;
                if (hh < 0 || hh > 4095 || $urandom_range(0, 3) == 0) hh = int'($urandom_range(0, 4095));
                if (vv < 0 || vv > 4095) vv = int'($urandom_range(0, 4095));
                step(12'(hh), 12'(vv), 1'($urandom), ($urandom_range(0, 9) == 0), 1'($urandom),
                     vb_r, 12'($urandom));
            end
            step(12'd0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        end

        // Async reset between edges: outputs clear immediately, centre reverts
        xpos = 12'd600;
        ypos = 12'd384;
        vpulse();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_now", all_outs(), 40'h0);
        @(posedge clk_in);
        #1;
        check("async_rst_held", all_outs(), 40'h0);
        rst_n = 1'b1;
        reset_model();
        step(12'd7, 12'd9, 1'b1, 1'b0, 1'b1, 1'b0, 12'h123);
        check("post_rst_first", all_outs(), 40'h0);
        step(12'd0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        check("post_rst_second", all_outs(), {12'd7, 12'd9, 1'b1, 1'b0, 1'b1, 1'b0, 12'h123});
        pixel(12'd512, 12'd384, 1'b0, 1'b0, GRN, PUCK, "rst_centre_init");
        pixel(12'd600, 12'd384, 1'b0, 1'b0, GRN, GRN,  "rst_centre_old");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
